// File: rtl/mem_arbiter_if.sv
// Bus bundle between the memory arbiter, its three requesters and the RAM port.
// The arbiter connects through the slave modport; the environment drives the master side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    logic              uploading;
    logic              up_req;
    logic [ADDR_W-1:0] up_addr;
    logic [DATA_W-1:0] up_data;
    logic              up_gnt;
    logic [ADDR_W:0]   up_count;

    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;

    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;

    modport slave (
        input  uploading, up_req, up_addr, up_data,
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_addr,
        input  mem_out,
        output up_gnt, up_count,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        output dbg_gnt, dbg_rvalid, dbg_rdata,
        output mem_en, mem_wr, mem_addr, mem_in
    );

    modport master (
        output uploading, up_req, up_addr, up_data,
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output dbg_req, dbg_addr,
        output mem_out,
        input  up_gnt, up_count,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dbg_gnt, dbg_rvalid, dbg_rdata,
        input  mem_en, mem_wr, mem_addr, mem_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: exclusive upload sessions, otherwise round-robin between
// CPU and debug readers. All grants and RAM commands are registered.
module mem_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic          clk,
    input  logic          res,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        SHARED = 2'd0,
        UPLOAD = 2'd1,
        RESUME = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] UP_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_reg, state_next;

    logic              armed_reg;
    logic              prio_dbg_reg, prio_dbg_next;
    logic [ADDR_W:0]   up_count_reg, up_count_next;

    logic              up_gnt_reg, up_gnt_next;
    logic              cpu_gnt_reg, cpu_gnt_next;
    logic              dbg_gnt_reg, dbg_gnt_next;
    logic              mem_en_reg;
    logic              mem_wr_reg, mem_wr_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_in_reg, mem_in_next;

    logic              cpu_pend_reg, dbg_pend_reg;
    logic              cpu_rvalid_reg, dbg_rvalid_reg;
    logic [DATA_W-1:0] cpu_rdata_reg, dbg_rdata_reg;

    logic              shared_ok;
    logic              cpu_win;
    logic              dbg_win;

    // Next-state, grant selection and RAM command for the following cycle.
    always_comb begin
        state_next    = state_reg;
        prio_dbg_next = prio_dbg_reg;
        up_count_next = up_count_reg;
        up_gnt_next   = 1'b0;
        cpu_gnt_next  = 1'b0;
        dbg_gnt_next  = 1'b0;
        mem_wr_next   = 1'b0;
        mem_addr_next = '0;
        mem_in_next   = '0;
        shared_ok     = 1'b0;
        cpu_win       = 1'b0;
        dbg_win       = 1'b0;

        case (state_reg)
            SHARED: begin
                if (bus.uploading) begin
                    state_next    = UPLOAD;
                    up_count_next = '0;
                end else begin
                    shared_ok = 1'b1;
                end
            end
            UPLOAD: begin
                if (!bus.uploading) begin
                    state_next = RESUME;
                end else if (bus.up_req) begin
                    up_gnt_next   = 1'b1;
                    mem_wr_next   = 1'b1;
                    mem_addr_next = bus.up_addr;
                    mem_in_next   = bus.up_data;
                    if (up_count_reg != UP_MAX) begin
                        up_count_next = up_count_reg + 1'b1;
                    end
                end
            end
            RESUME: begin
                // The dead cycle is the one spent in RESUME; its exit edge may grant again.
                state_next = SHARED;
                shared_ok  = !bus.uploading;
            end
            default: begin
                state_next = SHARED;
            end
        endcase

        // Ties go to whichever requester was not granted last.
        if (shared_ok && armed_reg) begin
            cpu_win = bus.cpu_req && (!bus.dbg_req || !prio_dbg_reg);
            dbg_win = bus.dbg_req && !cpu_win;
        end

        if (cpu_win) begin
            cpu_gnt_next  = 1'b1;
            mem_wr_next   = bus.cpu_wr;
            mem_addr_next = bus.cpu_addr;
            mem_in_next   = bus.cpu_wdata;
            prio_dbg_next = 1'b1;
        end else if (dbg_win) begin
            dbg_gnt_next  = 1'b1;
            mem_addr_next = bus.dbg_addr;
            prio_dbg_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_reg <= SHARED;
        end else begin
            state_reg <= state_next;
        end
    end

    // armed_reg holds off grants on the first edge after reset release.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            armed_reg    <= 1'b0;
            prio_dbg_reg <= 1'b0;
            up_count_reg <= '0;
            up_gnt_reg   <= 1'b0;
            cpu_gnt_reg  <= 1'b0;
            dbg_gnt_reg  <= 1'b0;
            mem_en_reg   <= 1'b0;
            mem_wr_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_in_reg   <= '0;
        end else begin
            armed_reg    <= 1'b1;
            prio_dbg_reg <= prio_dbg_next;
            up_count_reg <= up_count_next;
            up_gnt_reg   <= up_gnt_next;
            cpu_gnt_reg  <= cpu_gnt_next;
            dbg_gnt_reg  <= dbg_gnt_next;
            mem_en_reg   <= up_gnt_next | cpu_gnt_next | dbg_gnt_next;
            mem_wr_reg   <= mem_wr_next;
            mem_addr_reg <= mem_addr_next;
            mem_in_reg   <= mem_in_next;
        end
    end

    // Read return: RAM data appears the cycle after the grant and is captured at its end.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cpu_pend_reg   <= 1'b0;
            dbg_pend_reg   <= 1'b0;
            cpu_rvalid_reg <= 1'b0;
            dbg_rvalid_reg <= 1'b0;
            cpu_rdata_reg  <= '0;
            dbg_rdata_reg  <= '0;
        end else begin
            cpu_pend_reg   <= cpu_gnt_reg & ~mem_wr_reg;
            dbg_pend_reg   <= dbg_gnt_reg;
            cpu_rvalid_reg <= cpu_pend_reg;
            dbg_rvalid_reg <= dbg_pend_reg;
            if (cpu_pend_reg) begin
                cpu_rdata_reg <= bus.mem_out;
            end
            if (dbg_pend_reg) begin
                dbg_rdata_reg <= bus.mem_out;
            end
        end
    end

    assign bus.up_gnt     = up_gnt_reg;
    assign bus.up_count   = up_count_reg;
    assign bus.cpu_gnt    = cpu_gnt_reg;
    assign bus.cpu_rvalid = cpu_rvalid_reg;
    assign bus.cpu_rdata  = cpu_rdata_reg;
    assign bus.dbg_gnt    = dbg_gnt_reg;
    assign bus.dbg_rvalid = dbg_rvalid_reg;
    assign bus.dbg_rdata  = dbg_rdata_reg;
    assign bus.mem_en     = mem_en_reg;
    assign bus.mem_wr     = mem_wr_reg;
    assign bus.mem_addr   = mem_addr_reg;
    assign bus.mem_in     = mem_in_reg;
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, CPU-memory address width.
REQ-002 Parameter DATA_W, default 8, CPU-memory data width.
REQ-003 clk  input  1  single clock for all logic (CPU-memory port A clock).
REQ-004 res  input  1  reset: asynchronous, active-low.
REQ-005 uploading  input  1  upload session active; only the upload requester is served.
REQ-006 up_req / up_addr / up_data  input  1 / ADDR_W / DATA_W  upload write request.
REQ-007 up_gnt  output  1  upload write issued.
REQ-008 cpu_req / cpu_wr / cpu_addr / cpu_wdata  input  1 / 1 / ADDR_W / DATA_W  CPU access request.
REQ-009 cpu_gnt / cpu_rvalid  output  1 / 1  CPU access issued / CPU read data valid.
REQ-010 cpu_rdata  output  DATA_W  CPU read data.
REQ-011 dbg_req / dbg_addr  input  1 / ADDR_W  debug read-only request.
REQ-012 dbg_gnt / dbg_rvalid / dbg_rdata  output  1 / 1 / DATA_W  debug grant, valid, data.
REQ-013 mem_en / mem_wr / mem_addr / mem_in  output  1 / 1 / ADDR_W / DATA_W  RAM port command.
REQ-014 mem_out  input  DATA_W  RAM read data, valid one cycle after mem_en.
REQ-015 up_count  output  ADDR_W+1  writes issued in the current or last upload session.

Function
REQ-016 FSM states SHARED, UPLOAD, RESUME; SHALL be the only states.
REQ-017 SHARED->UPLOAD when uploading=1 at a rising edge; up_count cleared to 0 on that edge.
REQ-018 UPLOAD->RESUME when uploading=0; RESUME->SHARED unconditionally after one cycle.
REQ-019 RESUME: mem_en=0, no grants.
REQ-020 Requests sampled at each rising edge; the winner's gnt and mem_en/mem_wr/mem_addr/mem_in are registered and asserted for exactly the next cycle.
REQ-021 At most one gnt high per cycle; mem_en high iff some gnt high.
REQ-022 A req high on an edge where its gnt is high counts as a new request; back-to-back streaming yields one grant per cycle.
REQ-023 Dropping req before gnt withdraws the request with no side effect.
REQ-024 UPLOAD: only up_req granted, mem_wr=1, mem_addr=up_addr, mem_in=up_data; cpu/dbg requests held off.
REQ-025 SHARED: up_req ignored; cpu and dbg arbitrated round-robin.
REQ-026 Round-robin: single requester always wins; both requesting -> the one not granted last wins; pointer updates on every shared grant.
REQ-027 dbg grants: mem_wr=0; cpu grants: mem_wr=cpu_wr, mem_in=cpu_wdata.
REQ-028 Read grant in cycle N -> rvalid for that requester high exactly in cycle N+2, rdata = mem_out captured at end of N+1; writes produce no rvalid.
REQ-029 rdata holds its last value when rvalid=0.
REQ-030 up_count increments by 1 per up_gnt, saturates at 2^ADDR_W, holds after session ends.
REQ-031 uploading rising while a CPU/dbg read is in flight: rvalid still delivered at N+2.
REQ-032 Outputs glitch-free registered; no combinational path from req to gnt or mem_*.

Reset
REQ-033 res=0 asynchronously forces: state SHARED, all gnt/rvalid/mem_en/mem_wr 0, mem_addr/mem_in/rdata 0, up_count 0, round-robin pointer favours cpu next.
REQ-034 Reset mid-access drops pending rvalid; first grant possible on the second rising edge after res rises.

Verification
REQ-035 cpu_req read addr 0x200 held one cycle, RAM[0x200]=0xA5 -> cpu_gnt next cycle, cpu_rvalid two cycles later, cpu_rdata=0xA5.
REQ-036 cpu_req and dbg_req held high 6 cycles -> grants alternate cpu,dbg,cpu,dbg,cpu,dbg; never both high.
REQ-037 uploading=1, up_req streaming 16 writes 0x000-0x00F -> 16 consecutive up_gnt, mem_wr=1, up_count=16; cpu_req held meanwhile gets no grant.
REQ-038 uploading falls with cpu_req high -> one RESUME cycle with mem_en=0, then cpu_gnt.
REQ-039 res asserted in the cycle after a dbg grant -> dbg_rvalid never asserted, all outputs 0 immediately.
REQ-040 4096+1 upload writes in one session -> up_count saturates at 4096.
